// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants, coordinate type, motion FSM states and axis step helper
//
// Purpose: common definitions for the bouncing-box pixel source.
//   H_ACTIVE_DEF / V_ACTIVE_DEF : default visible area
//   coord_t                     : 10-bit pixel coordinate
//   motion_state_e              : IDLE, MOVE_X, MOVE_Y
//   axis_step()                 : one-axis move/reflect rule shared by both axes
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int COORD_W      = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_X = 2'd1,
    MOVE_Y = 2'd2
  } motion_state_e;

  typedef struct packed {
    coord_t pos;
    logic   dir;
    logic   hit;
  } axis_step_t;

  // Compares run at 11 bits so pos+box+step cannot wrap for any legal
  // 10-bit position.
  function automatic axis_step_t axis_step(
    input coord_t      pos,
    input logic        dir,
    input logic [10:0] span,
    input logic [10:0] box,
    input logic [10:0] step
  );
    axis_step_t  r;
    logic [10:0] pos_w;
    pos_w = {1'b0, pos};
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    if (dir) begin
      if (pos_w + box + step > span) begin
        r.pos = coord_t'(span - box);
        r.dir = 1'b0;
        r.hit = 1'b1;
      end else begin
        r.pos = coord_t'(pos_w + step);
      end
    end else begin
      if (pos_w < step) begin
        r.pos = '0;
        r.dir = 1'b1;
        r.hit = 1'b1;
      end else begin
        r.pos = coord_t'(pos_w - step);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_box_motion.sv
// rtl/vga_box_motion.sv - per-frame box motion FSM, position/direction registers, hit pulse
//
// Ports:
//   clock, reset_n : pixel clock, asynchronous active-low reset
//   frame_tick_i   : start-of-vblank pulse, accepted only in IDLE
//   pause_i        : blocks a frame update when high in IDLE
//   box_x_o/box_y_o: current top-left corner of the box
//   hit_o          : one-cycle pulse in the IDLE cycle after MOVE_Y if any axis reflected
module vga_box_motion
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BOX_SIZE = 16,
  parameter int STEP     = 2,
  parameter int X_INIT   = 100,
  parameter int Y_INIT   = 80
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   frame_tick_i,
  input  logic   pause_i,
  output coord_t box_x_o,
  output coord_t box_y_o,
  output logic   hit_o
);

  localparam logic [10:0] SPAN_X = 11'(H_ACTIVE);
  localparam logic [10:0] SPAN_Y = 11'(V_ACTIVE);
  localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);

  motion_state_e state_q, state_d;
  logic          move_x, move_y;

  coord_t     x_q, x_d, y_q, y_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic       hit_x_q, hit_x_d;
  logic       hit_q, hit_d;
  axis_step_t sx, sy;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_tick_i && !pause_i) state_d = MOVE_X;
      MOVE_X:  state_d = MOVE_Y;
      MOVE_Y:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    move_x = (state_q == MOVE_X);
    move_y = (state_q == MOVE_Y);
  end

  always_comb begin
    sx = axis_step(x_q, dir_x_q, SPAN_X, BOX_W, STEP_W);
    sy = axis_step(y_q, dir_y_q, SPAN_Y, BOX_W, STEP_W);
  end

  // The X reflection is held until MOVE_Y so a corner bounce merges into
  // one pulse, registered to land in the following IDLE cycle.
  always_comb begin
    x_d     = x_q;
    dir_x_d = dir_x_q;
    hit_x_d = hit_x_q;
    y_d     = y_q;
    dir_y_d = dir_y_q;
    hit_d   = 1'b0;
    if (move_x) begin
      x_d     = sx.pos;
      dir_x_d = sx.dir;
      hit_x_d = sx.hit;
    end
    if (move_y) begin
      y_d     = sy.pos;
      dir_y_d = sy.dir;
      hit_d   = hit_x_q | sy.hit;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= coord_t'(X_INIT);
      y_q     <= coord_t'(Y_INIT);
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      hit_x_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      hit_x_q <= hit_x_d;
      hit_q   <= hit_d;
    end
  end

  assign box_x_o = x_q;
  assign box_y_o = y_q;
  assign hit_o   = hit_q;

endmodule

// File: rtl/vga_bounce_box.sv
// rtl/vga_bounce_box.sv - bouncing box pixel source feeding the VGA timing block
//
// Optional feature: define VGA_BORDER_EN to draw an 8-pixel green frame
// around the active area (box still has priority).
//
// Ports:
//   clock, reset_n       : 25 MHz pixel clock, asynchronous active-low reset
//   i_pxl_col, i_pxl_row : current pixel coordinate
//   i_video_on           : coordinate is inside the active area
//   i_frame_tick         : start-of-vblank pulse, triggers one motion update
//   i_pause              : freezes motion while high
//   o_R, o_G, o_B        : registered 1-bit colour levels (1-clock latency)
//   o_hit                : one-cycle pulse when the box reflects
module vga_bounce_box
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BOX_SIZE = 16,
  parameter int STEP     = 2,
  parameter int X_INIT   = 100,
  parameter int Y_INIT   = 80
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [9:0]   i_pxl_col,
  input  logic [9:0]   i_pxl_row,
  input  logic         i_video_on,
  input  logic         i_frame_tick,
  input  logic         i_pause,
  output logic         o_R,
  output logic         o_G,
  output logic         o_B,
  output logic         o_hit
);

  localparam logic [10:0] BOX_W = 11'(BOX_SIZE);

  coord_t     box_x, box_y;
  logic [2:0] rgb_q, rgb_d;
  logic       in_box;

  vga_box_motion #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE),
    .STEP     (STEP),
    .X_INIT   (X_INIT),
    .Y_INIT   (Y_INIT)
  ) u_motion (
    .clock        (clock),
    .reset_n      (reset_n),
    .frame_tick_i (i_frame_tick),
    .pause_i      (i_pause),
    .box_x_o      (box_x),
    .box_y_o      (box_y),
    .hit_o        (o_hit)
  );

  // Upper bound written as col < x+BOX so the 11-bit sum covers boxes
  // touching the far edge without a -1 underflow case.
  always_comb begin
    in_box = ({1'b0, i_pxl_col} >= {1'b0, box_x}) &&
             ({1'b0, i_pxl_col} <  {1'b0, box_x} + BOX_W) &&
             ({1'b0, i_pxl_row} >= {1'b0, box_y}) &&
             ({1'b0, i_pxl_row} <  {1'b0, box_y} + BOX_W);
  end

`ifdef VGA_BORDER_EN
  localparam logic [10:0] H_EDGE = 11'(H_ACTIVE - 8);
  localparam logic [10:0] V_EDGE = 11'(V_ACTIVE - 8);
  logic in_border;

  always_comb begin
    in_border = (i_pxl_col < 10'd8) || ({1'b0, i_pxl_col} >= H_EDGE) ||
                (i_pxl_row < 10'd8) || ({1'b0, i_pxl_row} >= V_EDGE);
  end
`endif

  always_comb begin
    rgb_d = 3'b001;
    if (!i_video_on) begin
      rgb_d = 3'b000;
    end else if (in_box) begin
      rgb_d = 3'b111;
`ifdef VGA_BORDER_EN
    end else if (in_border) begin
      rgb_d = 3'b010;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rgb_q <= 3'b000;
    else          rgb_q <= rgb_d;
  end

  assign o_R = rgb_q[2];
  assign o_G = rgb_q[1];
  assign o_B = rgb_q[0];

endmodule

// File: tb/tb_vga_bounce_box.sv
// tb/tb_vga_bounce_box.sv - self-checking bench for vga_bounce_box
module tb_vga_bounce_box;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] col = '0;
  logic [9:0] row = '0;
  logic       von = 1'b0;
  logic       tick = 1'b0;
  logic       pause = 1'b0;

  logic r_a, g_a, b_a, hit_a;
  logic r_b, g_b, b_b, hit_b;

  int n_checks = 0;
  int n_fail   = 0;
  int hits_a   = 0;
  int hits_b   = 0;

`ifdef VGA_BORDER_EN
  localparam logic [2:0] EDGE_BG = 3'b010;
`else
  localparam logic [2:0] EDGE_BG = 3'b001;
`endif

  // instance 0: default geometry; instance 1: small square area with an
  // odd step, so both axes always reflect together (corner bounces).
  localparam int P_H[2]    = '{640, 64};
  localparam int P_V[2]    = '{480, 64};
  localparam int P_BOX[2]  = '{16, 16};
  localparam int P_STEP[2] = '{2, 3};
  localparam int P_XI[2]   = '{100, 5};
  localparam int P_YI[2]   = '{80, 5};

  always #5 clock = ~clock;

  vga_bounce_box dut_a (
    .clock(clock), .reset_n(reset_n), .i_pxl_col(col), .i_pxl_row(row),
    .i_video_on(von), .i_frame_tick(tick), .i_pause(pause),
    .o_R(r_a), .o_G(g_a), .o_B(b_a), .o_hit(hit_a)
  );

  vga_bounce_box #(
    .H_ACTIVE(64), .V_ACTIVE(64), .BOX_SIZE(16), .STEP(3), .X_INIT(5), .Y_INIT(5)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .i_pxl_col(col), .i_pxl_row(row),
    .i_video_on(von), .i_frame_tick(tick), .i_pause(pause),
    .o_R(r_b), .o_G(g_b), .o_B(b_b), .o_hit(hit_b)
  );

  // ---------------- reference model ----------------
  int       mx[2], my[2], mdx[2], mdy[2];
  int       px[2], py[2], pdx[2], pdy[2], phx[2], phy[2];
  int       upd_phase = 0;
  logic [2:0] exp_rgb[2];
  logic       exp_hit[2];

  task automatic axis(input int pos, input int dir, input int span, input int box,
                      input int step, output int npos, output int ndir, output int nhit);
    npos = pos; ndir = dir; nhit = 0;
    if (dir == 1) begin
      if (pos + box + step > span) begin npos = span - box; ndir = 0; nhit = 1; end
      else npos = pos + step;
    end else begin
      if (pos < step) begin npos = 0; ndir = 1; nhit = 1; end
      else npos = pos - step;
    end
  endtask

  function automatic logic [2:0] pix(input int i, input int c, input int r, input bit v);
    if (!v) return 3'b000;
    if (c >= mx[i] && c < mx[i] + P_BOX[i] && r >= my[i] && r < my[i] + P_BOX[i])
      return 3'b111;
`ifdef VGA_BORDER_EN
    if (c < 8 || c >= P_H[i] - 8 || r < 8 || r >= P_V[i] - 8) return 3'b010;
`endif
    return 3'b001;
  endfunction

  // A frame update accepted at one edge moves X on the next edge, Y on the
  // one after, and the hit shows for the cycle after that.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        mx[i] = P_XI[i]; my[i] = P_YI[i]; mdx[i] = 1; mdy[i] = 1;
        exp_rgb[i] = 3'b000; exp_hit[i] = 1'b0;
      end
      upd_phase = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp_rgb[i] = pix(i, int'(col), int'(row), von);
        exp_hit[i] = 1'b0;
      end
      if (upd_phase == 0) begin
        if (tick && !pause) begin
          for (int i = 0; i < 2; i++) begin
            axis(mx[i], mdx[i], P_H[i], P_BOX[i], P_STEP[i], px[i], pdx[i], phx[i]);
            axis(my[i], mdy[i], P_V[i], P_BOX[i], P_STEP[i], py[i], pdy[i], phy[i]);
          end
          upd_phase = 1;
        end
      end else if (upd_phase == 1) begin
        for (int i = 0; i < 2; i++) begin mx[i] = px[i]; mdx[i] = pdx[i]; end
        upd_phase = 2;
      end else begin
        for (int i = 0; i < 2; i++) begin
          my[i] = py[i]; mdy[i] = pdy[i];
          exp_hit[i] = (phx[i] != 0) || (phy[i] != 0);
        end
        upd_phase = 0;
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // single compare process against the model, every cycle
  always @(negedge clock) begin
    check("rgb_a", {1'b0, r_a, g_a, b_a}, {1'b0, exp_rgb[0]});
    check("hit_a", {3'b0, hit_a}, {3'b0, exp_hit[0]});
    check("rgb_b", {1'b0, r_b, g_b, b_b}, {1'b0, exp_rgb[1]});
    check("hit_b", {3'b0, hit_b}, {3'b0, exp_hit[1]});
    if (reset_n && hit_a === 1'b1) hits_a++;
    if (reset_n && hit_b === 1'b1) hits_b++;
  end

  // ---------------- stimulus ----------------
  task automatic rand_pix();
    int k;
    k = int'($urandom_range(0, 3));
    if (k < 2) begin
      col = 10'(mx[k] + int'($urandom_range(0, 19)) - 2);
      row = 10'(my[k] + int'($urandom_range(0, 19)) - 2);
    end else if (k == 2) begin
      col = 10'($urandom_range(0, 1023));
      row = 10'($urandom_range(0, 1023));
    end else begin
      col = 10'($urandom_range(0, 70));
      row = 10'($urandom_range(0, 70));
    end
    von = ($urandom_range(0, 7) != 0);
  endtask

  task automatic cyc(input bit t, input bit p);
    @(negedge clock); #1;
    tick = t; pause = p;
    rand_pix();
  endtask

  task automatic do_tick(input bit p);
    cyc(1'b1, p);
    repeat (4) cyc(1'b0, 1'b0);
  endtask

  task automatic probe(input string name, input bit sel_b, input int c, input int r,
                       input bit v, input logic [2:0] exp);
    @(negedge clock); #1;
    tick = 1'b0; pause = 1'b0;
    col = 10'(c); row = 10'(r); von = v;
    @(negedge clock);
    if (sel_b) check(name, {1'b0, r_b, g_b, b_b}, {1'b0, exp});
    else       check(name, {1'b0, r_a, g_a, b_a}, {1'b0, exp});
  endtask

  initial begin
    col = 10'd100; row = 10'd80; von = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_outs_a", {r_a, g_a, b_a, hit_a}, 4'b0000);
    check("reset_outs_b", {r_b, g_b, b_b, hit_b}, 4'b0000);
    #1 reset_n = 1'b1;

    probe("reset_box_in",   1'b0, 100, 80, 1'b1, 3'b111);
    probe("reset_origin",   1'b0, 0,   0,  1'b1, EDGE_BG);
    probe("video_off",      1'b0, 100, 80, 1'b0, 3'b000);
    probe("reset_box_far",  1'b0, 115, 95, 1'b1, 3'b111);
    probe("reset_box_out",  1'b0, 116, 95, 1'b1, 3'b001);

    do_tick(1'b1);
    probe("pause_box_in",   1'b0, 100, 80, 1'b1, 3'b111);
    probe("pause_box_out",  1'b0, 99,  80, 1'b1, 3'b001);
    probe("border_pixel",   1'b0, 3,   200, 1'b1, EDGE_BG);

    do_tick(1'b0);
    probe("move_box_in",    1'b0, 102, 82, 1'b1, 3'b111);
    probe("move_box_left",  1'b0, 101, 82, 1'b1, 3'b001);
    probe("move_box_far",   1'b0, 117, 97, 1'b1, 3'b111);
    probe("move_box_right", 1'b0, 118, 97, 1'b1, 3'b001);
    check("move_no_hit", 4'(hits_a), 4'd0);

    for (int t = 2; t <= 32; t++) begin
      do_tick(1'b0);
      if (t == 15) check("corner_hit_b_first", 4'(hits_b), 4'd1);
    end
    check("corner_hit_b_second", 4'(hits_b), 4'd2);
    probe("corner_b_origin",  1'b1, 0,  0,  1'b1, 3'b111);
    probe("corner_b_far",     1'b1, 15, 15, 1'b1, 3'b111);
    probe("corner_b_outside", 1'b1, 16, 15, 1'b1, 3'b001);

    for (int t = 33; t <= 262; t++) do_tick(1'b0);
    check("edge_hits_before", 4'(hits_a), 4'd1);
    do_tick(1'b0);
    check("edge_hits_after", 4'(hits_a), 4'd2);
    probe("edge_box_in",   1'b0, 624, 324, 1'b1, 3'b111);
    probe("edge_box_left", 1'b0, 623, 324, 1'b1, 3'b001);
    probe("edge_box_up",   1'b0, 624, 323, 1'b1, 3'b001);

    for (int i = 0; i < 15000; i++) begin
      if (i == 7000) begin
        cyc(1'b1, 1'b0);
        @(negedge clock); #1 reset_n = 1'b0; tick = 1'b0;
        repeat (2) @(negedge clock);
        #1 reset_n = 1'b1;
        probe("midreset_box_in",  1'b0, 100, 80, 1'b1, 3'b111);
        probe("midreset_box_out", 1'b0, 116, 95, 1'b1, 3'b001);
      end
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
